// File: rtl/waterfall_line_writer.sv
// Waterfall line writer: averages DECIMATE ADC samples into one 8-bit pixel and
// writes one framebuffer row per frame_start, scrolling the oldest row via row_base.
module waterfall_line_writer #(
  parameter int LINE_W       = 320,
  parameter int LINES        = 240,
  parameter int SAMPLE_WIDTH = 12,
  parameter int DECIMATE     = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    frame_start,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic [16:0]             ram_addr,
  output logic [7:0]              ram_wdata,
  output logic                    ram_we,
  output logic [7:0]              row_base,
  output logic                    line_done,
  output logic                    overrun
);

  localparam int ACC_W = SAMPLE_WIDTH + $clog2(DECIMATE);
  localparam int CNT_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int COL_W = $clog2(LINE_W);

  typedef enum logic [1:0] {IDLE, CAPTURE, FINISH} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt;
  logic [COL_W-1:0]   column;
  logic [7:0]         write_row;
  logic [7:0]         next_row;
  logic [16:0]        row_off;
  logic [16:0]        pix_addr;
  logic               last_pixel;

  // The default geometry uses shift-and-add so no multiplier is needed for row*320.
  generate
    if (LINE_W == 320) begin : g_shift_mul
      assign row_off = ({9'd0, write_row} << 8) + ({9'd0, write_row} << 6);
    end else begin : g_generic_mul
      assign row_off = 17'({9'd0, write_row} * 17'(LINE_W));
    end
  endgenerate

  assign pix_addr = row_off + 17'(column);
  assign acc_sum  = acc + ACC_W'(sample_data);
  assign next_row = (write_row == 8'(LINES - 1)) ? 8'd0 : write_row + 8'd1;

  // last_pixel marks the cycle the final write is on the bus, so FINISH never drives ram_we.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      column     <= '0;
      write_row  <= '0;
      last_pixel <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      row_base   <= '0;
      line_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start && enable) begin
            state      <= CAPTURE;
            column     <= '0;
            acc        <= '0;
            cnt        <= '0;
            last_pixel <= 1'b0;
          end
        end
        CAPTURE: begin
          if (frame_start) overrun <= 1'b1;
          if (last_pixel) begin
            state      <= FINISH;
            last_pixel <= 1'b0;
            line_done  <= 1'b1;
            write_row  <= next_row;
            row_base   <= next_row;
          end else if (sample_valid) begin
            if (cnt == CNT_W'(DECIMATE - 1)) begin
              ram_we    <= 1'b1;
              ram_wdata <= acc_sum[ACC_W-1 -: 8];
              ram_addr  <= pix_addr;
              acc       <= '0;
              cnt       <= '0;
              if (column == COL_W'(LINE_W - 1)) last_pixel <= 1'b1;
              else                              column     <= column + COL_W'(1);
            end else begin
              acc <= acc_sum;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        FINISH: begin
          if (frame_start) overrun <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_waterfall_line_writer.sv
// Directed bench: a default-geometry instance for pixel/line/overrun/gating/reset
// behaviour and a DECIMATE=1 instance to reach the full 240-row wrap quickly.
module tb_waterfall_line_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, enable, frame_start, sample_valid;
  logic [11:0] sample_data;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata, row_base;
  logic        ram_we, line_done, overrun;

  logic        w_resetn, w_enable, w_frame_start, w_sample_valid;
  logic [11:0] w_sample_data;
  logic [16:0] w_ram_addr;
  logic [7:0]  w_ram_wdata, w_row_base;
  logic        w_ram_we, w_line_done, w_overrun;

  int tests = 0;
  int fails = 0;
  int ld_count = 0;

  logic [24:0] wq[$];
  logic [24:0] bq[$];

  waterfall_line_writer dut (
    .clk(clk), .resetn(resetn), .enable(enable), .frame_start(frame_start),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .row_base(row_base), .line_done(line_done), .overrun(overrun)
  );

  waterfall_line_writer #(.LINE_W(320), .LINES(240), .SAMPLE_WIDTH(12), .DECIMATE(1)) dut_wrap (
    .clk(clk), .resetn(w_resetn), .enable(w_enable), .frame_start(w_frame_start),
    .sample_valid(w_sample_valid), .sample_data(w_sample_data),
    .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata), .ram_we(w_ram_we),
    .row_base(w_row_base), .line_done(w_line_done), .overrun(w_overrun)
  );

  // Capture every framebuffer write as {addr, data} away from the active edge.
  always @(negedge clk) begin
    if (ram_we)    wq.push_back({ram_addr, ram_wdata});
    if (w_ram_we)  bq.push_back({w_ram_addr, w_ram_wdata});
    if (line_done) ld_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic en, input logic sv, input logic [11:0] sd);
    frame_start  = fs;
    enable       = en;
    sample_valid = sv;
    sample_data  = sd;
    tick();
  endtask

  task automatic send_samples(input int n, input logic [11:0] sd, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, en, 1'b1, sd);
    sample_valid = 1'b0;
  endtask

  task automatic wait_line_done(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (line_done) found = 1'b1;
    end
    checkOutput(tag, found, 1'b1);
    tick();
  endtask

  task automatic check_line(input string tag, input int base, input logic [7:0] data);
    int bad_a, bad_d;
    bad_a = 0;
    bad_d = 0;
    checkOutput({tag, "_count"}, wq.size(), 320);
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i][24:8] !== 17'(base + i)) bad_a++;
      if (wq[i][7:0]  !== data)          bad_d++;
    end
    checkOutput({tag, "_addr_errs"}, bad_a, 0);
    checkOutput({tag, "_data_errs"}, bad_d, 0);
    wq.delete();
  endtask

  task automatic run_wrap_line(input logic [11:0] sd, inout int missed);
    logic found;
    w_frame_start = 1'b1;
    w_enable      = 1'b1;
    tick();
    w_frame_start  = 1'b0;
    w_sample_valid = 1'b1;
    w_sample_data  = sd;
    repeat (320) tick();
    w_sample_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (w_line_done) found = 1'b1;
    end
    if (!found) missed++;
    tick();
  endtask

  initial begin
    int ld_base, bad_a, bad_d, missed;

    resetn = 1'b0; enable = 1'b0; frame_start = 1'b0; sample_valid = 1'b0; sample_data = '0;
    w_resetn = 1'b0; w_enable = 1'b0; w_frame_start = 1'b0; w_sample_valid = 1'b0; w_sample_data = '0;
    tick();
    tick();
    checkOutput("rst_ram_we", ram_we, 1'b0);
    checkOutput("rst_ram_addr", ram_addr, 17'd0);
    checkOutput("rst_ram_wdata", ram_wdata, 8'd0);
    checkOutput("rst_row_base", row_base, 8'd0);
    checkOutput("rst_line_done", line_done, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);

    // Single pixel average.
    resetn = 1'b1;
    wq.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h100);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h200);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h300);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h400);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
    checkOutput("pix_count", wq.size(), 1);
    if (wq.size() > 0) begin
      checkOutput("pix_addr", wq[0][24:8], 17'd0);
      checkOutput("pix_data", wq[0][7:0], 8'h28);
    end
    checkOutput("pix_we_low", ram_we, 1'b0);
    checkOutput("pix_wdata_hold", ram_wdata, 8'h28);

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    wq.delete();

    // Full line of full-scale samples.
    ld_base = ld_count;
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    send_samples(1280, 12'hFFF, 1'b1);
    wait_line_done("full_line_done");
    check_line("full", 0, 8'hFF);
    checkOutput("full_ld_pulses", ld_count - ld_base, 1);
    checkOutput("full_row_base", row_base, 8'd1);
    checkOutput("full_overrun", overrun, 1'b0);

    // frame_start arriving mid-line after 100 pixels.
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    send_samples(400, 12'h800, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 12'h800);
    send_samples(879, 12'h800, 1'b1);
    wait_line_done("ovr_line_done");
    checkOutput("ovr_flag", overrun, 1'b1);
    check_line("ovr", 320, 8'h80);
    checkOutput("ovr_row_base", row_base, 8'd2);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    checkOutput("ovr_sticky", overrun, 1'b1);

    // enable low blocks starting a line.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
      send_samples(8, 12'h123, 1'b0);
    end
    repeat (3) tick();
    checkOutput("gate_no_writes", wq.size(), 0);
    checkOutput("gate_row_base", row_base, 8'd2);

    // enable dropped mid-line: line still completes, next start is blocked.
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    send_samples(200, 12'h400, 1'b1);
    send_samples(1080, 12'h400, 1'b0);
    wait_line_done("drop_line_done");
    check_line("drop", 640, 8'h40);
    checkOutput("drop_row_base", row_base, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    send_samples(8, 12'h400, 1'b0);
    repeat (3) tick();
    checkOutput("drop_next_blocked", wq.size(), 0);

    // Reset after 50 pixels abandons the line and restarts at row 0.
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    send_samples(200, 12'h200, 1'b1);
    resetn = 1'b0;
    tick();
    checkOutput("rstmid_partial_writes", wq.size(), 50);
    checkOutput("rstmid_we", ram_we, 1'b0);
    checkOutput("rstmid_overrun_clr", overrun, 1'b0);
    checkOutput("rstmid_row_base", row_base, 8'd0);
    resetn = 1'b1;
    wq.delete();
    send_samples(8, 12'h200, 1'b1);
    repeat (2) tick();
    checkOutput("rstmid_no_writes", wq.size(), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    send_samples(4, 12'h100, 1'b1);
    repeat (2) tick();
    checkOutput("rstmid_restart_count", wq.size(), 1);
    if (wq.size() > 0) begin
      checkOutput("rstmid_restart_addr", wq[0][24:8], 17'd0);
      checkOutput("rstmid_restart_data", wq[0][7:0], 8'h10);
    end
    resetn = 1'b0;
    tick();

    // Row wrap over all 240 rows on the DECIMATE=1 instance.
    w_resetn = 1'b1;
    bq.delete();
    missed = 0;
    for (int l = 0; l < 240; l++) run_wrap_line(12'hAB0, missed);
    checkOutput("wrap_line_done_missed", missed, 0);
    checkOutput("wrap_total_writes", bq.size(), 76800);
    bad_a = 0;
    bad_d = 0;
    for (int i = 0; i < bq.size(); i++) begin
      if (bq[i][24:8] !== 17'(i))  bad_a++;
      if (bq[i][7:0]  !== 8'hAB)   bad_d++;
    end
    checkOutput("wrap_addr_errs", bad_a, 0);
    checkOutput("wrap_data_errs", bad_d, 0);
    if (bq.size() == 76800) begin
      checkOutput("wrap_last_row_first", bq[76480][24:8], 17'd76480);
      checkOutput("wrap_last_row_last", bq[76799][24:8], 17'd76799);
    end
    checkOutput("wrap_row_base", w_row_base, 8'd0);
    bq.delete();
    run_wrap_line(12'h050, missed);
    checkOutput("wrap_next_count", bq.size(), 320);
    if (bq.size() > 0) begin
      checkOutput("wrap_next_addr", bq[0][24:8], 17'd0);
      checkOutput("wrap_next_data", bq[0][7:0], 8'h05);
    end
    checkOutput("wrap_next_row_base", w_row_base, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/waterfall_line_writer.md
WATERFALL_LINE_WRITER -- requirements
Module: waterfall_line_writer

Interface
REQ-001 The block SHALL have parameter LINE_W, default 320, meaning pixels per framebuffer row.
REQ-002 The block SHALL have parameter LINES, default 240, meaning rows in the framebuffer.
REQ-003 The block SHALL have parameter SAMPLE_WIDTH, default 12, meaning ADC sample bit depth.
REQ-004 The block SHALL have parameter DECIMATE, default 4 (power of two), meaning ADC samples averaged per pixel.
REQ-005 The block SHALL have port clk, input, 1 bit: the pixel clock, the only clock.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port enable, input, 1 bit: permits starting a new line.
REQ-008 The block SHALL have port frame_start, input, 1 bit: single-cycle pulse at the start of LCD lower blanking.
REQ-009 The block SHALL have port sample_valid, input, 1 bit: ADC ready strobe, one cycle per sample.
REQ-010 The block SHALL have port sample_data, input, SAMPLE_WIDTH bits: ADC sample, valid with sample_valid.
REQ-011 The block SHALL have port ram_addr, output, 17 bits: framebuffer write address.
REQ-012 The block SHALL have port ram_wdata, output, 8 bits: pixel value.
REQ-013 The block SHALL have port ram_we, output, 1 bit: framebuffer write enable.
REQ-014 The block SHALL have port row_base, output, 8 bits: oldest row, used as the scroll offset for the display reader.
REQ-015 The block SHALL have port line_done, output, 1 bit: single-cycle pulse after a row completes.
REQ-016 The block SHALL have port overrun, output, 1 bit: sticky flag set when frame_start arrives mid-line.

Function
REQ-017 The block SHALL implement states IDLE, CAPTURE and FINISH, and SHALL write at most one row per frame_start.
REQ-018 In IDLE, frame_start=1 with enable=1 SHALL move the block to CAPTURE with the column counter = 0 and the accumulator cleared; all other IDLE inputs SHALL be ignored.
REQ-019 In CAPTURE, each sample_valid SHALL add zero-extended sample_data into an accumulator of SAMPLE_WIDTH+log2(DECIMATE) bits and increment a sample counter.
REQ-020 On the DECIMATE-th sample_valid of a pixel, the next cycle SHALL assert ram_we for exactly one cycle, with ram_wdata = the accumulator's top 8 bits (including that final sample) and ram_addr = write_row*LINE_W + column.
REQ-021 The accumulator and sample counter SHALL clear in the same cycle as a pixel write, and a sample_valid in that cycle SHALL count as the first sample of the next pixel.
REQ-022 write_row*320 SHALL be computed as (write_row<<8)+(write_row<<6); maximum address 76799 SHALL fit in 17 bits without truncation.
REQ-023 After the write for column LINE_W-1, the block SHALL enter FINISH.
REQ-024 In FINISH (one cycle), the block SHALL pulse line_done, advance write_row (wrapping LINES-1 to 0), set row_base to the new write_row, and return to IDLE.
REQ-025 frame_start during CAPTURE or FINISH SHALL set overrun and be otherwise ignored; the line in progress SHALL continue.
REQ-026 overrun SHALL clear only on reset.
REQ-027 Deasserting enable mid-line SHALL NOT abort the line; it SHALL only block the next IDLE to CAPTURE transition.
REQ-028 ram_we SHALL be 0 in IDLE and FINISH.
REQ-029 ram_addr and ram_wdata SHALL hold their last values when ram_we is 0.

Reset
REQ-030 With resetn=0 at a clk edge, the block SHALL go to IDLE with ram_we=0, ram_addr=0, ram_wdata=0, row_base=0, line_done=0, overrun=0, write_row=0, column=0, and the accumulator and sample counter at 0.
REQ-031 Reset during CAPTURE SHALL abandon the partial line, produce no further writes, and restart writing at row 0.

Verification
REQ-032 Pixel value: enable=1, frame_start pulse, then samples 0x100, 0x200, 0x300, 0x400 -> one ram_we pulse, ram_addr=0, ram_wdata=0x28.
REQ-033 Full line: 1280 samples of 0xFFF -> 320 writes at addresses 0..319, all with ram_wdata=0xFF, then line_done once, row_base=1.
REQ-034 Row wrap: complete 240 lines -> last row written at addresses 76480..76799; after its line_done, row_base=0; next line writes from address 0.
REQ-035 Overrun: frame_start pulse after 100 pixels of a line -> overrun=1, line completes with all 320 writes, overrun stays 1 until resetn=0.
REQ-036 Gating: enable=0 with frame_start pulses and samples -> no ram_we; enable dropped mid-line -> line finishes, next frame_start ignored.
REQ-037 Reset mid-line: resetn=0 for 1 cycle after 50 pixels -> no writes until the next enabled frame_start, next write at ram_addr=0, row_base=0.
